chasing_led_top: RTL and testbench
==================================

Name: chasing_led_top

Overview:
Chasing-LED controller for a 16-LED board running on one 100 MHz clock. A single lit LED moves back and forth across led[15:0]. The 8-bit switch bank sets the step speed, and a stop input freezes motion. An 8-digit multiplexed seven-segment display shows the LED position (decimal) and the speed setting (hex).

Parameters:
- BASE_DIV, 1_000_000: clocks per base tick (10 ms at 100 MHz). Legal range ≥2.
- REFRESH_BITS, 17: a new display digit is selected every 2^REFRESH_BITS clocks. Legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stop  in  1  level; 1 = freeze chase position and speed counters.
- sw  in  8  speed setting; one step every (sw+1) base ticks.
- led  out  16  one-hot LED pattern; bit i lit when position = i.
- seg  out  7  cathodes, active-low; seg[0]=a … seg[6]=g.
- an  out  8  digit anodes, active-low; an[k] selects digit k.

Behaviour:
- Reset (synchronous, highest priority, wins over stop):
  - pos=0, dir=up, base_cnt=0, step_cnt=0, refresh counter=0.
  - led=16'h0001, an=8'hFE, seg=7'h40 (digit 0 showing '0').
- base_cnt counts 0..BASE_DIV-1 and wraps. tick = (base_cnt==BASE_DIV-1) and stop=0.
- On tick:
  - If step_cnt ≥ sw: step_cnt←0 and pos advances one place.
  - Otherwise step_cnt increments.
  - The ≥ compare means lowering sw mid-count never stalls.
- Step period from reset with stop=0 is (sw+1)·BASE_DIV clocks. sw=0 gives one step per base tick.
- led is registered: led = 1<<pos, updated in the same edge as pos.
- Default motion is ping-pong:
  - dir=up: pos 14→15 sets dir=down. dir=down: pos 1→0 sets dir=up.
  - Endpoints are each shown for one step period. Sequence: 0,1,…,15,14,…,1,0,1,…
- stop=1: base_cnt, step_cnt, pos and dir all hold. On release, counting resumes from the held values.
- sw is sampled every clock; no synchronizer is required beyond the registered compare.
- Display refresh:
  - A free-running refresh counter of REFRESH_BITS+3 bits is never stopped by stop.
  - Its top 3 bits select digit k (0..7), cycling 0→7→0.
  - an = ~(1<<k) for active digits; an=8'hFF for blank digits.
- Digit contents:
  - k=0: pos mod 10.
  - k=1: pos/10 (0 or 1).
  - k=4: sw[3:0] in hex.
  - k=5: sw[7:4] in hex.
  - k=2,3,6,7: blank, seg=7'h7F, and that anode is not driven low.
- Hex font, active-low with g as MSB:
  0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- seg and an are registered together, so they never disagree for a cycle.
- Reset asserted mid-step or mid-refresh: everything returns to the reset values on the next edge.

Optional Feature:
- Macro CHASE_WRAP_EN.
- Defined:
  - Motion is circular: pos 15→0 when dir=up.
  - sw[7]=1 selects dir=down (pos 0→15). sw[7] is sampled at each step.
  - Step period uses only sw[6:0]: (sw[6:0]+1) base ticks.
- Not defined: ping-pong as above, and all 8 bits of sw set the speed.
- Display content is identical in both builds.

Test Plan:
- Bench parameters: BASE_DIV=4, REFRESH_BITS=2, clock period 10 ns.
- Reset: hold reset 1 cycle → led=0001, an=FE, seg=40. stop=1 during reset still yields the reset values.
- Speed, sw=8'h00:
  - led shifts every 4 clocks: 0001,0002,…,8000.
  - Then 4000 (bounce at 15), down to 0001, then 0002.
  - Check 31 steps.
- Slow speed, sw=8'hFF: first step occurs exactly 256·4=1024 clocks after reset release (led 0001→0002).
- Stop, sw=0: assert stop when led=0010 for 50 clocks → led stays 0010. Release → next step to 0020 within 4 clocks.
- Display, sw=8'hA5, pos=12:
  - Scan shows an=FE/seg=24 ('2') and an=FD/seg=79 ('1').
  - an=EF/seg=12 ('5') and an=DF/seg=08 ('A').
  - Digits 2,3,6,7 give an=FF.
- Speed change: sw 8'hFF→8'h00 mid-count (step_cnt=100) → step occurs on the next tick. With CHASE_WRAP_EN and sw=8'h80: led 0001→8000→4000.

Source files
------------

// File: rtl/chasing_led_if.sv
// chasing_led_if: control inputs and display outputs of the chasing-LED board
interface chasing_led_if;
  logic       stop;
  logic [7:0] sw;
  logic [15:0] led;
  logic [6:0] seg;
  logic [7:0] an;
  modport master(output stop, sw, input led, seg, an);
  modport slave(input stop, sw, output led, seg, an);
endinterface

// File: rtl/chasing_led_top.sv
// chasing_led_top: ping-pong chasing LED with speed/position seven-segment display
// Optional CHASE_WRAP_EN: circular motion, sw[7] picks direction, sw[6:0] sets speed.
module chasing_led_top #(
  parameter int BASE_DIV     = 1_000_000,
  parameter int REFRESH_BITS = 17
) (
  input logic          clk,
  input logic          reset,
  chasing_led_if.slave bus
);
  localparam int BW = $clog2(BASE_DIV);
  logic [BW-1:0]         r_base;
  logic [7:0]            r_step;
  logic [3:0]            r_pos;
  logic [15:0]           r_led;
  logic [REFRESH_BITS+2:0] r_ref;
  logic [6:0]            r_seg;
  logic [7:0]            r_an;
  logic                  w_tick;
  logic                  w_step;
  logic [7:0]            w_spd;
  logic [3:0]            w_pos_nxt;
  logic [2:0]            w_k;
  logic [3:0]            w_dig;
  logic                  w_blank;
  logic [6:0]            w_seg;
  logic [7:0]            w_an;
  assign w_tick = (r_base == BW'(BASE_DIV - 1)) && !bus.stop;
  assign w_step = w_tick && (r_step >= w_spd);
`ifdef CHASE_WRAP_EN
  assign w_spd     = {1'b0, bus.sw[6:0]};
  assign w_pos_nxt = bus.sw[7] ? r_pos - 4'd1 : r_pos + 4'd1;
`else
  typedef enum logic {UP, DN} dir_t;
  dir_t r_dir, w_dir_nxt;
  assign w_spd = bus.sw;
  always_comb begin
    w_pos_nxt = (r_dir == UP) ? r_pos + 4'd1 : r_pos - 4'd1;
    w_dir_nxt = (r_dir == UP && r_pos == 4'd14) ? DN :
                (r_dir == DN && r_pos == 4'd1)  ? UP : r_dir;
  end
  always_ff @(posedge clk) begin
    if (reset) r_dir <= UP;
    else if (w_step) r_dir <= w_dir_nxt;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0;
      r_step <= '0;
      r_pos  <= '0;
      r_led  <= 16'h0001;
    end else begin
      if (!bus.stop) r_base <= w_tick ? '0 : r_base + 1'b1;
      if (w_tick) r_step <= w_step ? 8'd0 : r_step + 8'd1;
      if (w_step) begin
        r_pos <= w_pos_nxt;
        r_led <= 16'd1 << w_pos_nxt;
      end
    end
  end
  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'h0: font = 7'h40; 4'h1: font = 7'h79; 4'h2: font = 7'h24; 4'h3: font = 7'h30;
      4'h4: font = 7'h19; 4'h5: font = 7'h12; 4'h6: font = 7'h02; 4'h7: font = 7'h78;
      4'h8: font = 7'h00; 4'h9: font = 7'h10; 4'hA: font = 7'h08; 4'hB: font = 7'h03;
      4'hC: font = 7'h46; 4'hD: font = 7'h21; 4'hE: font = 7'h06; default: font = 7'h0E;
    endcase
  endfunction
  // digits 2,3,6,7 are exactly those with k[1] set
  always_comb begin
    w_k     = r_ref[REFRESH_BITS+2 -: 3];
    w_blank = w_k[1];
    w_dig   = (w_k == 3'd0) ? ((r_pos >= 4'd10) ? r_pos - 4'd10 : r_pos) :
              (w_k == 3'd1) ? {3'b000, r_pos >= 4'd10} :
              (w_k == 3'd4) ? bus.sw[3:0] : bus.sw[7:4];
    w_an    = w_blank ? 8'hFF : ~(8'd1 << w_k);
    w_seg   = w_blank ? 7'h7F : font(w_dig);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref <= '0;
      r_an  <= 8'hFE;
      r_seg <= 7'h40;
    end else begin
      r_ref <= r_ref + 1'b1;
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end
  assign bus.led = r_led;
  assign bus.seg = r_seg;
  assign bus.an  = r_an;
endmodule

// File: tb/tb_chasing_led_top.sv
// tb_chasing_led_top: directed stimulus with a step-count model checked every cycle
module tb_chasing_led_top;
  localparam int BD = 4;
  localparam int RB = 2;
`ifdef CHASE_WRAP_EN
  localparam int          SLOW_EDGES = 512;
  localparam logic [15:0] SLOW_LED   = 16'h8000;
`else
  localparam int          SLOW_EDGES = 1024;
  localparam logic [15:0] SLOW_LED   = 16'h0002;
`endif
  logic clk = 1'b0;
  logic reset;
  chasing_led_if tif();
  chasing_led_top #(.BASE_DIV(BD), .REFRESH_BITS(RB)) dut (.clk(clk), .reset(reset), .bus(tif.slave));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int m_phase, m_ticks, m_n, m_ref, m_pos, m_k, m_d, m_spd;
  logic [15:0] m_led;
  logic [6:0]  m_seg;
  logic [7:0]  m_an;
  bit m_valid = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int exp_pos(input int j);
`ifdef CHASE_WRAP_EN
    return j % 16;
`else
    int p = j % 30;
    return (p <= 15) ? p : 30 - p;
`endif
  endfunction
  // model: position follows the count of completed steps
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_ticks = 0; m_n = 0; m_ref = 0; m_pos = 0;
      m_led = 16'h0001; m_an = 8'hFE; m_seg = 7'h40; m_valid = 1'b1;
    end else begin
      m_k = (m_ref >> RB) % 8;
      m_d = (m_k == 0) ? m_pos % 10 : (m_k == 1) ? m_pos / 10 :
            (m_k == 4) ? int'(tif.sw) % 16 : int'(tif.sw) / 16;
      if (m_k == 0 || m_k == 1 || m_k == 4 || m_k == 5) begin
        m_an = 8'hFF ^ (8'd1 << m_k);
        m_seg = font[m_d];
      end else begin
        m_an = 8'hFF;
        m_seg = 7'h7F;
      end
      m_ref = (m_ref + 1) % (1 << (RB + 3));
`ifdef CHASE_WRAP_EN
      m_spd = int'(tif.sw[6:0]);
`else
      m_spd = int'(tif.sw);
`endif
      if (!tif.stop) begin
        if (m_phase == BD - 1) begin
          m_phase = 0;
          if (m_ticks >= m_spd) begin
            m_ticks = 0;
            m_n++;
`ifdef CHASE_WRAP_EN
            m_pos = tif.sw[7] ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
`else
            m_pos = exp_pos(m_n);
`endif
          end else m_ticks++;
        end else m_phase++;
      end
      m_led = 16'd1 << m_pos;
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_led", {16'h0, tif.led}, {16'h0, m_led});
      chk("model_seg", {25'h0, tif.seg}, {25'h0, m_seg});
      chk("model_an", {24'h0, tif.an}, {24'h0, m_an});
    end
  end
  task automatic rst_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  logic [7:0] seen;
  initial begin
    reset = 1'b1; tif.stop = 1'b1; tif.sw = 8'h00;
    @(negedge clk);
    chk("rst_led", {16'h0, tif.led}, 32'h0001);
    chk("rst_an", {24'h0, tif.an}, 32'hFE);
    chk("rst_seg", {25'h0, tif.seg}, 32'h40);
    reset = 1'b0; tif.stop = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      cyc(3);
      chk("chase_hold", {16'h0, tif.led}, 32'd1 << exp_pos(j - 1));
      cyc(1);
      chk("chase_step", {16'h0, tif.led}, 32'd1 << exp_pos(j));
    end
    tif.sw = 8'hFF;
    rst_pulse();
    cyc(SLOW_EDGES - 1);
    chk("slow_hold", {16'h0, tif.led}, 32'h0001);
    cyc(1);
    chk("slow_step", {16'h0, tif.led}, {16'h0, SLOW_LED});
    tif.sw = 8'h00;
    rst_pulse();
    cyc(16);
    chk("stop_pre", {16'h0, tif.led}, 32'h0010);
    tif.stop = 1'b1;
    cyc(50);
    chk("stop_held", {16'h0, tif.led}, 32'h0010);
    tif.stop = 1'b0;
    cyc(3);
    chk("stop_resume_hold", {16'h0, tif.led}, 32'h0010);
    cyc(1);
    chk("stop_resume_step", {16'h0, tif.led}, 32'h0020);
    rst_pulse();
    cyc(48);
    chk("disp_pos12", {16'h0, tif.led}, 32'h1000);
    tif.stop = 1'b1; tif.sw = 8'hA5;
    cyc(1);
    seen = '0;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      case (tif.an)
        8'hFE: begin seen[0] = 1'b1; chk("disp_d0", {25'h0, tif.seg}, 32'h24); end
        8'hFD: begin seen[1] = 1'b1; chk("disp_d1", {25'h0, tif.seg}, 32'h79); end
        8'hEF: begin seen[4] = 1'b1; chk("disp_d4", {25'h0, tif.seg}, 32'h12); end
        8'hDF: begin seen[5] = 1'b1; chk("disp_d5", {25'h0, tif.seg}, 32'h08); end
        8'hFF: begin seen[7] = 1'b1; chk("disp_blank", {25'h0, tif.seg}, 32'h7F); end
        default: chk("disp_an", {24'h0, tif.an}, 32'hFF);
      endcase
    end
    chk("disp_seen", {24'h0, seen}, 32'hB3);
    tif.stop = 1'b0; tif.sw = 8'hFF;
    rst_pulse();
    cyc(400);
    tif.sw = 8'h00;
    cyc(3);
    chk("spdchg_hold", {16'h0, tif.led}, 32'h0001);
    cyc(1);
    chk("spdchg_step", {16'h0, tif.led}, 32'h0002);
`ifdef CHASE_WRAP_EN
    tif.sw = 8'h80;
    rst_pulse();
    cyc(4);
    chk("wrap_down1", {16'h0, tif.led}, 32'h8000);
    cyc(4);
    chk("wrap_down2", {16'h0, tif.led}, 32'h4000);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
